// File: rtl/rtc_lector_if.sv
// Multiplexed address/data bus between the RTC reader (master) and the external RTC chip (slave).
// Strobes are active-low; a_d low marks an address phase.
interface rtc_lector_if;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;

    modport master (
        input  ad_in,
        output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
    );

    modport slave (
        output ad_in,
        input  ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
    );
endinterface

// File: rtl/rtc_lector.sv
// Refreshes nine BCD time/date/chronometer bytes from the RTC chip, one register per read cycle,
// and publishes all of them in a single commit cycle so the display never sees a torn value.
module rtc_lector #(
    parameter int unsigned T_PHASE = 5  // cycles per bus phase, 2..255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    rtc_lector_if.master bus,
    output logic [7:0]   hora,
    output logic [7:0]   min,
    output logic [7:0]   seg,
    output logic [7:0]   dia,
    output logic [7:0]   mes,
    output logic [7:0]   ano,
    output logic [7:0]   c_hora,
    output logic [7:0]   c_min,
    output logic [7:0]   c_seg,
    output logic         busy,
    output logic         done
);
    typedef enum logic [2:0] {
        StIdle, StCmdAddr, StCmdGap, StRdAddr, StRdGap1, StRdData, StRdGap2, StCommit
    } state_e;

    localparam logic [7:0] PhaseLast = 8'(T_PHASE - 1);
    localparam logic [3:0] IdxLast   = 4'd8;
    localparam logic [7:0] CmdXfer   = 8'hF0;

    state_e     state_q, state_d;
    logic [7:0] phase_q, phase_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] shadow_q [9];
    logic [7:0] shadow_d [9];
    logic [7:0] out_q [9];
    logic [7:0] out_d [9];
    logic       cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d, a_d_q, a_d_d;
    logic       ad_oe_q, ad_oe_d, busy_q, busy_d, done_q, done_d;
    logic [7:0] ad_out_q, ad_out_d;
    logic       phase_end;

    // Index order: seg, min, hora, dia, mes, ano, c_seg, c_min, c_hora.
    function automatic logic [7:0] reg_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h21;
            4'd1:    return 8'h22;
            4'd2:    return 8'h23;
            4'd3:    return 8'h24;
            4'd4:    return 8'h25;
            4'd5:    return 8'h26;
            4'd6:    return 8'h41;
            4'd7:    return 8'h42;
            default: return 8'h43;
        endcase
    endfunction

    assign phase_end = (phase_q == PhaseLast);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        out_d    = out_q;

        case (state_q)
            StIdle:    if (start) state_d = StCmdAddr;
            StCmdAddr: if (phase_end) state_d = StCmdGap;
            StCmdGap: begin
                if (phase_end) begin
                    state_d = StRdAddr;
                    idx_d   = '0;
                end
            end
            StRdAddr:  if (phase_end) state_d = StRdGap1;
            StRdGap1:  if (phase_end) state_d = StRdData;
            StRdData: begin
                if (phase_end) begin
                    shadow_d[idx_q] = bus.ad_in;
                    state_d         = StRdGap2;
                end
            end
            StRdGap2: begin
                if (phase_end) begin
                    if (idx_q == IdxLast) begin
                        state_d = StCommit;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = StRdAddr;
                    end
                end
            end
            default:   state_d = StIdle;
        endcase

        if (state_d != state_q || state_q == StIdle) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + 8'd1;
        end

        // Outputs are decoded from the next state so they are registered yet aligned with it.
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        a_d_d    = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = '0;
        case (state_d)
            StCmdAddr, StRdAddr: begin
                cs_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                a_d_d    = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = (state_d == StCmdAddr) ? CmdXfer : reg_addr(idx_d);
            end
            StRdData: begin
                cs_n_d = 1'b0;
                rd_n_d = 1'b0;
            end
            default: ;
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StCommit);
        if (state_d == StCommit) out_d = shadow_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            phase_q  <= '0;
            idx_q    <= '0;
            for (int i = 0; i < 9; i++) begin
                shadow_q[i] <= '0;
                out_q[i]    <= '0;
            end
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            a_d_q    <= 1'b1;
            ad_oe_q  <= 1'b0;
            ad_out_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            cs_n_q   <= cs_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            a_d_q    <= a_d_d;
            ad_oe_q  <= ad_oe_d;
            ad_out_q <= ad_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.cs_n   = cs_n_q;
    assign bus.rd_n   = rd_n_q;
    assign bus.wr_n   = wr_n_q;
    assign bus.a_d    = a_d_q;
    assign bus.ad_oe  = ad_oe_q;
    assign bus.ad_out = ad_out_q;

    assign seg    = out_q[0];
    assign min    = out_q[1];
    assign hora   = out_q[2];
    assign dia    = out_q[3];
    assign mes    = out_q[4];
    assign ano    = out_q[5];
    assign c_seg  = out_q[6];
    assign c_min  = out_q[7];
    assign c_hora = out_q[8];
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_rtc_lector.sv
// Directed bench for rtc_lector: one instance at T_PHASE=5, one at T_PHASE=2, each with an RTC
// model that only presents valid data on the last cycle of the read strobe.
module tb_rtc_lector;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start5 = 1'b0;
    logic start2 = 1'b0;
    bit   dset = 1'b0;
    bit   sel = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   proto_bad = 0;

    always #5 clk = ~clk;

    rtc_lector_if b5 ();
    rtc_lector_if b2 ();

    logic [7:0] hora5, min5, seg5, dia5, mes5, ano5, ch5, cm5, cs5;
    logic [7:0] hora2, min2, seg2, dia2, mes2, ano2, ch2, cm2, cs2;
    logic       busy5, done5, busy2, done2;

    rtc_lector #(.T_PHASE(5)) dut5 (
        .clk(clk), .reset(reset), .start(start5), .bus(b5),
        .hora(hora5), .min(min5), .seg(seg5), .dia(dia5), .mes(mes5), .ano(ano5),
        .c_hora(ch5), .c_min(cm5), .c_seg(cs5), .busy(busy5), .done(done5)
    );

    rtc_lector #(.T_PHASE(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .bus(b2),
        .hora(hora2), .min(min2), .seg(seg2), .dia(dia2), .mes(mes2), .ano(ano2),
        .c_hora(ch2), .c_min(cm2), .c_seg(cs2), .busy(busy2), .done(done2)
    );

    logic [71:0] v5, v2;
    assign v5 = {hora5, min5, seg5, dia5, mes5, ano5, ch5, cm5, cs5};
    assign v2 = {hora2, min2, seg2, dia2, mes2, ano2, ch2, cm2, cs2};

    // Packed {hora,min,seg,dia,mes,ano,c_hora,c_min,c_seg}.
    localparam logic [71:0] SetA = 72'h23_59_45_31_12_16_01_30_07;
    localparam logic [71:0] SetB = 72'h09_34_12_28_02_99_10_44_55;

    function automatic logic [7:0] rtc_data(input logic [7:0] a, input bit s);
        case (a)
            8'h21:   return s ? 8'h12 : 8'h45;
            8'h22:   return s ? 8'h34 : 8'h59;
            8'h23:   return s ? 8'h09 : 8'h23;
            8'h24:   return s ? 8'h28 : 8'h31;
            8'h25:   return s ? 8'h02 : 8'h12;
            8'h26:   return s ? 8'h99 : 8'h16;
            8'h41:   return s ? 8'h55 : 8'h07;
            8'h42:   return s ? 8'h44 : 8'h30;
            8'h43:   return s ? 8'h10 : 8'h01;
            default: return 8'hEE;
        endcase
    endfunction

    // RTC model: latch address on write strobe, count read-strobe cycles, garbage until last one.
    logic [7:0] lat5, lat2;
    int         rdc5, rdc2;
    always @(posedge clk) begin
        if (!b5.cs_n && !b5.wr_n && !b5.a_d) lat5 <= b5.ad_out;
        if (!b2.cs_n && !b2.wr_n && !b2.a_d) lat2 <= b2.ad_out;
        rdc5 <= b5.rd_n ? 0 : rdc5 + 1;
        rdc2 <= b2.rd_n ? 0 : rdc2 + 1;
    end
    assign b5.ad_in = (!b5.rd_n && rdc5 == 4) ? rtc_data(lat5, dset) : 8'hEE;
    assign b2.ad_in = (!b2.rd_n && rdc2 == 1) ? rtc_data(lat2, dset) : 8'hEE;

    // Bus monitor on the selected instance: address-phase log, phase lengths, strobe rules.
    logic       m_cs, m_ad, m_rd;
    logic [7:0] m_out;
    logic [7:0] alog[$];
    int         alen[$];
    int         rlen[$];
    int         arun = 0;
    int         rrun = 0;
    assign m_cs  = sel ? b2.cs_n : b5.cs_n;
    assign m_ad  = sel ? b2.a_d : b5.a_d;
    assign m_rd  = sel ? b2.rd_n : b5.rd_n;
    assign m_out = sel ? b2.ad_out : b5.ad_out;

    always @(negedge clk) begin
        if (!m_cs && !m_ad) begin
            if (arun == 0) alog.push_back(m_out);
            else if (m_out !== alog[$]) proto_bad++;
            arun++;
        end else if (arun != 0) begin
            alen.push_back(arun);
            arun = 0;
        end
        if (!m_rd) rrun++;
        else if (rrun != 0) begin
            rlen.push_back(rrun);
            rrun = 0;
        end
        if ((!b5.rd_n && !b5.wr_n) || (b5.ad_oe && !b5.rd_n)) proto_bad++;
        if ((!b2.rd_n && !b2.wr_n) || (b2.ad_oe && !b2.rd_n)) proto_bad++;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One refresh: start sampled at the next posedge (edge 0), observe cycles 1..38T+2.
    task automatic run(input bit s, input int t, input logic [71:0] old_v,
                       input logic [71:0] new_v, input bit mid);
        logic [7:0]  exp_addr [10];
        logic [71:0] obs;
        int lat, dn, torn;
        logic d, b;
        exp_addr = '{8'hF0, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
        lat  = 38 * t + 1;
        dn   = 0;
        torn = 0;
        alog.delete();
        alen.delete();
        rlen.delete();
        sel = s;
        if (s) start2 = 1'b1;
        else start5 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        start5 = 1'b0;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            if (mid) begin
                if (s) start2 = (c == 50 || c == 100);
                else start5 = (c == 50 || c == 100);
            end
            obs = s ? v2 : v5;
            d   = s ? done2 : done5;
            b   = s ? busy2 : busy5;
            if (d) dn++;
            if (c < lat && obs !== old_v) torn++;
            if (c == 1) chk("busy_after_edge0", b, 1);
            if (c == lat - 1) chk("hold_before_commit", obs, old_v);
            if (c == lat) begin
                chk("commit_values", obs, new_v);
                chk("done_at_commit", d, 1);
                chk("busy_in_commit", b, 1);
            end
            if (c == lat + 1) chk("busy_dropped", b, 0);
        end
        chk("torn_cycles", torn, 0);
        chk("done_pulses", dn, 1);
        chk("addr_phase_count", alog.size(), 10);
        for (int i = 0; i < 10 && i < alog.size(); i++) chk("addr_value", alog[i], exp_addr[i]);
        for (int i = 0; i < alen.size(); i++) chk("addr_phase_len", alen[i], t);
        chk("read_phase_count", rlen.size(), 9);
        for (int i = 0; i < rlen.size(); i++) chk("read_phase_len", rlen[i], t);
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_outputs5", v5, 0);
        chk("rst_outputs2", v2, 0);
        chk("rst_strobes5", {b5.cs_n, b5.rd_n, b5.wr_n, b5.a_d}, 4'b1111);
        chk("rst_strobes2", {b2.cs_n, b2.rd_n, b2.wr_n, b2.a_d}, 4'b1111);
        chk("rst_oe_out5", {b5.ad_oe, b5.ad_out}, 0);
        chk("rst_busy_done5", {busy5, done5}, 0);
        chk("rst_busy_done2", {busy2, done2}, 0);
        @(negedge clk);

        // Full refresh with starts at cycles 50 and 100 ignored
        dset = 1'b0;
        run(1'b0, 5, 72'h0, SetA, 1'b1);

        // Back-to-back start at edge 192 with new data: torn-value check against SetA
        dset = 1'b1;
        run(1'b0, 5, SetA, SetB, 1'b0);

        // Reset during RD_DATA of index 4 (cycles 101..105)
        dset = 1'b0;
        @(negedge clk);
        start5 = 1'b1;
        @(posedge clk);
        #1;
        start5 = 1'b0;
        repeat (103) @(negedge clk);
        chk("in_rd_data_idx4", {b5.rd_n, b5.cs_n, b5.a_d}, 3'b001);
        chk("old_values_mid", v5, SetB);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_strobes", {b5.cs_n, b5.rd_n, b5.wr_n, b5.a_d}, 4'b1111);
        chk("midrst_oe_out", {b5.ad_oe, b5.ad_out}, 0);
        chk("midrst_outputs", v5, 0);
        chk("midrst_busy_done", {busy5, done5}, 0);
        repeat (2) @(negedge clk);
        run(1'b0, 5, 72'h0, SetA, 1'b0);

        // T_PHASE=2: latency 77, sample only in second RD_DATA cycle
        @(negedge clk);
        run(1'b1, 2, 72'h0, SetA, 1'b0);

        chk("protocol_rules", proto_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
